// File: rtl/led_pio_sequencer.sv
// -----------------------------------------------------------------------------
// led_pio_sequencer
//   Autonomous LED pattern sequencer. A CPU-facing Avalon-MM control slave sets
//   the pattern mode, step period and enable. An Avalon-MM write master issues
//   exactly one PIO data-register write per pattern step, so LED animation runs
//   without software involvement.
//
// Parameters
//   TICK_DIV  clk cycles per base tick (>= 2)
//   DATA_W    LED/pattern width (only 8 is supported)
//   PIO_ADDR  word address of the PIO data register, driven on m_address
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   address/chipselect/write_n/writedata/readdata   control slave
//       0 CTRL   [0] EN, [2:1] MODE, [3] IRQ enable (only with LED_SEQ_IRQ_EN)
//       1 PERIOD step interval = PERIOD+1 base ticks
//       2 STATUS [0] busy, [1] wrap_flag (read-only, any write clears wrap_flag)
//       3 current pattern (read-only)
//   m_address/m_chipselect/m_write_n/m_writedata/m_waitrequest   write master
//   irq                        level pattern-wrap interrupt
//
// Configuration
//   `define LED_SEQ_IRQ_EN : irq = wrap_flag & CTRL[3]; otherwise irq is tied 0
//   and CTRL[3] is neither stored nor read back.
// -----------------------------------------------------------------------------
module led_pio_sequencer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DATA_W   = 8,
  parameter logic [1:0]  PIO_ADDR = 2'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [1:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  output logic              irq
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DATA_W-1:0] PAT_ZERO = '0;
  localparam logic [DATA_W-1:0] PAT_ALL  = '1;
  localparam logic [DATA_W-1:0] PAT_ONE  = DATA_W'(1);
  localparam logic [DATA_W-1:0] PAT_TOP  = PAT_ONE << (DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;
  typedef enum logic [1:0] {MODE_WALK, MODE_BOUNCE, MODE_BLINK, MODE_COUNT} mode_t;

  state_t state, state_next;

  // Control-slave registers
  logic              ctrl_en;
  mode_t             ctrl_mode;
  logic              ctrl_irq_bit;
  logic [DATA_W-1:0] period;
  logic              wrap_flag;

  // Sequencer datapath
  logic [DATA_W-1:0] pattern, pat_next;
  mode_t             run_mode, run_mode_next;   // mode that produced the current pattern
  logic              bounce_down, down_next;
  logic [PW-1:0]     presc;
  logic [DATA_W-1:0] interval;
  logic              tick, wrap_evt, cnt_clear, cnt_adv;

  logic  slave_wr, ctrl_wr, period_wr, status_wr;
  logic  start_en;
  mode_t start_mode;

  assign slave_wr  = chipselect & ~write_n;
  assign ctrl_wr   = slave_wr & (address == 2'd0);
  assign period_wr = slave_wr & (address == 2'd1);
  assign status_wr = slave_wr & (address == 2'd2);

  // Starting from IDLE looks through the CTRL write so the first beat appears
  // on the cycle right after the EN=1 write.
  assign start_en   = ctrl_wr ? writedata[0] : ctrl_en;
  assign start_mode = ctrl_wr ? mode_t'(writedata[2:1]) : ctrl_mode;
  assign tick       = (presc == TICK_LAST);

  function automatic logic [DATA_W-1:0] seed_of(input mode_t m);
    case (m)
      MODE_BLINK: seed_of = PAT_ALL;
      MODE_COUNT: seed_of = PAT_ZERO;
      default:    seed_of = PAT_ONE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_next    = state;
    pat_next      = pattern;
    down_next     = bounce_down;
    run_mode_next = run_mode;
    wrap_evt      = 1'b0;
    cnt_clear     = 1'b0;
    cnt_adv       = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clear = 1'b1;
        if (start_en) begin
          state_next    = S_WRITE;
          pat_next      = seed_of(start_mode);
          down_next     = 1'b0;
          run_mode_next = start_mode;
        end
      end
      S_WRITE: begin
        // Counters are frozen here, so a stall stretches the step.
        if (!m_waitrequest) state_next = ctrl_en ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!ctrl_en) begin
          state_next = S_IDLE;
          cnt_clear  = 1'b1;
        end else if (tick && (interval >= period)) begin
          state_next = S_WRITE;
          cnt_clear  = 1'b1;
          if (ctrl_mode != run_mode) begin
            // Mode changed while running: restart from the new mode's seed.
            pat_next      = seed_of(ctrl_mode);
            down_next     = 1'b0;
            run_mode_next = ctrl_mode;
          end else begin
            case (run_mode)
              MODE_WALK: begin
                pat_next = {pattern[DATA_W-2:0], pattern[DATA_W-1]};
                wrap_evt = (pattern == PAT_TOP);
              end
              MODE_BOUNCE: begin
                if (bounce_down) begin
                  pat_next = pattern >> 1;
                  if (pat_next == PAT_ONE) begin
                    wrap_evt  = 1'b1;
                    down_next = 1'b0;
                  end
                end else if (pattern == PAT_TOP) begin
                  pat_next  = pattern >> 1;
                  down_next = 1'b1;
                end else begin
                  pat_next = pattern << 1;
                end
              end
              MODE_BLINK: begin
                pat_next = ~pattern;
                wrap_evt = (pattern == PAT_ZERO);
              end
              default: begin
                pat_next = pattern + 1'b1;
                wrap_evt = (pattern == PAT_ALL);
              end
            endcase
          end
        end else begin
          cnt_adv = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern     <= PAT_ZERO;
      run_mode    <= MODE_WALK;
      bounce_down <= 1'b0;
      presc       <= '0;
      interval    <= '0;
    end else begin
      pattern     <= pat_next;
      run_mode    <= run_mode_next;
      bounce_down <= down_next;
      if (cnt_clear) begin
        presc    <= '0;
        interval <= '0;
      end else if (cnt_adv) begin
        if (tick) begin
          presc    <= '0;
          interval <= interval + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_WALK;
      period    <= '0;
      wrap_flag <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en   <= writedata[0];
        ctrl_mode <= mode_t'(writedata[2:1]);
      end
      if (period_wr) period <= writedata;
      // A wrap in the same cycle as a STATUS write wins.
      if (wrap_evt)       wrap_flag <= 1'b1;
      else if (status_wr) wrap_flag <= 1'b0;
    end
  end

`ifdef LED_SEQ_IRQ_EN
  logic ctrl_irq_en;

  always_ff @(posedge clk) begin
    if (reset)        ctrl_irq_en <= 1'b0;
    else if (ctrl_wr) ctrl_irq_en <= writedata[3];
  end

  assign ctrl_irq_bit = ctrl_irq_en;
  assign irq          = wrap_flag & ctrl_irq_en;
`else
  assign ctrl_irq_bit = 1'b0;
  assign irq          = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[3:0] = {ctrl_irq_bit, ctrl_mode, ctrl_en};
      2'd1:    readdata      = period;
      2'd2:    readdata[1:0] = {wrap_flag, state != S_IDLE};
      default: readdata      = pattern;
    endcase
  end

  assign m_address    = PIO_ADDR;
  assign m_chipselect = (state == S_WRITE);
  assign m_write_n    = (state != S_WRITE);
  assign m_writedata  = pattern;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_pio_sequencer
//   Self-checking bench for led_pio_sequencer with TICK_DIV=4. Inputs change on
//   the falling edge; a monitor logs every accepted master beat (cycle, data,
//   STATUS.wrap_flag) shortly after the falling edge. Expected patterns, wrap
//   points and step spacing come from closed-form rules per mode.
// -----------------------------------------------------------------------------
module tb_led_pio_sequencer;

  localparam int TICK_DIV = 4;
`ifdef LED_SEQ_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] address = 2'd0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] writedata = 8'h00;
  logic [7:0] readdata;
  logic [1:0] m_address;
  logic       m_chipselect;
  logic       m_write_n;
  logic [7:0] m_writedata;
  logic       m_waitrequest = 1'b0;
  logic       irq;

  led_pio_sequencer #(.TICK_DIV(TICK_DIV), .DATA_W(8), .PIO_ADDR(2'd0)) dut (
    .clk(clk), .reset(reset),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .irq(irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        wrap;
  } beat_t;
  beat_t beats[$];

  // Beat monitor: address is parked at STATUS while sequences run.
  always begin
    @(negedge clk);
    #2;
    if (m_chipselect === 1'b1 && m_write_n === 1'b0 && m_waitrequest === 1'b0)
      beats.push_back('{cyc, m_writedata, readdata[1]});
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_pat(input int m, input int i);
    int k;
    case (m)
      0: return 8'(1 << (i % 8));
      1: begin
        k = i % 14;
        return (k <= 7) ? 8'(1 << k) : 8'(1 << (14 - k));
      end
      2: return (i % 2 == 0) ? 8'hFF : 8'h00;
      default: return 8'(i % 256);
    endcase
  endfunction

  // First beat index produced by a wrapping step, per mode.
  function automatic bit model_wrap(input int m, input int i);
    case (m)
      0: return i >= 8;
      1: return i >= 14;
      2: return i >= 2;
      default: return i >= 256;
    endcase
  endfunction

  function automatic int model_gap(input int per);
    return (per + 1) * TICK_DIV + 1;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic do_reset();
    reset = 1'b1;
    chipselect = 1'b0;
    write_n = 1'b1;
    m_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int waited = 0;
    while (beats.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_beats_seen"}, 32'(beats.size() >= n), 32'd1);
  endtask

  // Wait for a falling edge inside a WRITE cycle once min_beats were accepted.
  task automatic wait_write(input int min_beats, input string name);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(beats.size() >= min_beats && m_chipselect === 1'b1) && waited < 300);
    check({name, "_write_seen"}, 32'(m_chipselect), 32'd1);
  endtask

  task automatic run_scen(input logic [1:0] mode, input logic [7:0] per, input int n, input string name);
    int unsigned wr_cyc;
    do_reset();
    bus_write(2'd1, per);
    beats.delete();
    bus_write(2'd0, {5'b0, mode, 1'b1});
    wr_cyc = cyc;
    address = 2'd2;
    wait_beats(n, n * model_gap(int'(per)) + 20, name);
    bus_write(2'd0, 8'h00);
    address = 2'd2;
    if (beats.size() >= n) begin
      check($sformatf("%s_first_latency", name), beats[0].cyc, wr_cyc);
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_data[%0d]", name, i), beats[i].data, model_pat(int'(mode), i));
        check($sformatf("%s_wrap[%0d]", name, i), beats[i].wrap, model_wrap(int'(mode), i));
        if (i > 0)
          check($sformatf("%s_gap[%0d]", name, i), beats[i].cyc - beats[i-1].cyc,
                model_gap(int'(per)));
      end
    end
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } reg_vec_t;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] period;
    int         nbeats;
  } scen_t;

  reg_vec_t reg_tab[6];
  scen_t    scen_tab[4];

  initial begin
    int nb;
    int idx;
    logic [1:0] rmode;
    logic [7:0] rper;

    reg_tab[0] = '{2'd0, 8'hFE, IRQ_BUILD ? 8'h0E : 8'h06};
    reg_tab[1] = '{2'd1, 8'hA5, 8'hA5};
    reg_tab[2] = '{2'd2, 8'h55, 8'h00};
    reg_tab[3] = '{2'd3, 8'h3C, 8'h00};
    reg_tab[4] = '{2'd1, 8'h00, 8'h00};
    reg_tab[5] = '{2'd0, 8'h08, IRQ_BUILD ? 8'h08 : 8'h00};

    scen_tab[0] = '{2'd0, 8'd0, 17};   // walk, two full wraps
    scen_tab[1] = '{2'd1, 8'd1, 30};   // bounce, wrap only on descending 01
    scen_tab[2] = '{2'd2, 8'd0, 6};    // blink
    scen_tab[3] = '{2'd3, 8'd2, 5};    // count, slower period

    // Reset state
    do_reset();
    check("rst_m_chipselect", m_chipselect, 1'b0);
    check("rst_m_write_n", m_write_n, 1'b1);
    check("rst_m_writedata", m_writedata, 8'h00);
    check("rst_m_address", m_address, 2'd0);
    check("rst_irq", irq, 1'b0);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("rst_readdata[%0d]", a), readdata, 8'h00);
    end

    // Register write / read-back table (EN stays 0 throughout)
    foreach (reg_tab[i]) begin
      bus_write(reg_tab[i].addr, reg_tab[i].wdata);
      address = reg_tab[i].addr;
      #1;
      check($sformatf("reg_rd[%0d]", i), readdata, reg_tab[i].exp_rd);
      check($sformatf("reg_idle_cs[%0d]", i), m_chipselect, 1'b0);
    end

    // Mode sequences from the table
    foreach (scen_tab[i])
      run_scen(scen_tab[i].mode, scen_tab[i].period, scen_tab[i].nbeats,
               $sformatf("scen%0d", i));

    // Randomized mode / period runs
    for (int r = 0; r < 4; r++) begin
      rmode = 2'($urandom_range(0, 3));
      rper  = 8'($urandom_range(0, 3));
      run_scen(rmode, rper, 10 + int'($urandom_range(0, 10)), $sformatf("rand%0d", r));
    end

    // Stall on the 2nd beat: held 4 cycles, later steps keep full spacing
    do_reset();
    bus_write(2'd1, 8'd0);
    beats.delete();
    bus_write(2'd0, 8'h01);
    address = 2'd2;
    wait_write(1, "stall");
    m_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) m_waitrequest = 1'b0;
      check($sformatf("stall_cs[%0d]", k), m_chipselect, 1'b1);
      check($sformatf("stall_data[%0d]", k), m_writedata, 8'h02);
      @(negedge clk);
    end
    wait_beats(3, 40, "stall");
    if (beats.size() >= 3) begin
      check("stall_gap_stretched", beats[1].cyc - beats[0].cyc, model_gap(0) + 3);
      check("stall_gap_after", beats[2].cyc - beats[1].cyc, model_gap(0));
      check("stall_beat1_data", beats[1].data, 8'h02);
      check("stall_beat2_data", beats[2].data, 8'h04);
    end

    // EN cleared during a stalled WRITE: the beat completes, then IDLE
    wait_write(0, "enclr");
    m_waitrequest = 1'b1;
    nb = beats.size();
    bus_write(2'd0, 8'h00);
    check("enclr_cs_held", m_chipselect, 1'b1);
    m_waitrequest = 1'b0;
    @(negedge clk);
    address = 2'd2;
    #1;
    check("enclr_busy", readdata[0], 1'b0);
    check("enclr_beat_done", beats.size(), nb + 1);
    repeat (30) @(negedge clk);
    check("enclr_no_more_beats", beats.size(), nb + 1);
    check("enclr_cs_low", m_chipselect, 1'b0);

    // Reset asserted in the middle of a stalled WRITE
    bus_write(2'd0, 8'h01);
    check("rstmid_in_write", m_chipselect, 1'b1);
    m_waitrequest = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    address = 2'd2;
    #1;
    check("rstmid_cs", m_chipselect, 1'b0);
    check("rstmid_write_n", m_write_n, 1'b1);
    check("rstmid_writedata", m_writedata, 8'h00);
    check("rstmid_status", readdata, 8'h00);
    reset = 1'b0;
    m_waitrequest = 1'b0;

    // Mode change while running: next step loads the blink seed
    do_reset();
    bus_write(2'd1, 8'd0);
    beats.delete();
    bus_write(2'd0, 8'h01);
    address = 2'd2;
    wait_write(3, "modechg");
    bus_write(2'd0, 8'h05);
    address = 2'd2;
    idx = beats.size();
    wait_beats(idx + 2, 40, "modechg");
    if (beats.size() >= idx + 2) begin
      check("modechg_seed", beats[idx].data, 8'hFF);
      check("modechg_next", beats[idx + 1].data, 8'h00);
    end
    bus_write(2'd0, 8'h00);

    // Count mode through FE -> FF -> 00 wrap, with irq enable requested
    do_reset();
    bus_write(2'd1, 8'd0);
    beats.delete();
    bus_write(2'd0, 8'h0F);
    address = 2'd2;
    check("cnt_irq_before", irq, 1'b0);
    wait_beats(257, 257 * model_gap(0) + 20, "cnt");
    check("cnt_irq_after_wrap", irq, IRQ_BUILD);
    bus_write(2'd0, 8'h0E);
    if (beats.size() >= 257) begin
      for (int i = 250; i < 257; i++) begin
        check($sformatf("cnt_data[%0d]", i), beats[i].data, model_pat(3, i));
        check($sformatf("cnt_wrap[%0d]", i), beats[i].wrap, model_wrap(3, i));
      end
    end
    repeat (2) @(negedge clk);
    address = 2'd2;
    #1;
    check("cnt_status_wrap_idle", readdata, 8'h02);
    check("cnt_irq_held", irq, IRQ_BUILD);
    bus_write(2'd2, 8'h00);
    address = 2'd2;
    #1;
    check("cnt_status_cleared", readdata, 8'h00);
    check("cnt_irq_cleared", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
